// File: rtl/usbdev_pkg.sv
// Shared types and line constants for the full-speed USB device transmit path.
package usbdev_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } usb_tx_state_e;

    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;
    localparam logic       USB_LINE_J    = 1'b1;
    localparam logic       USB_LINE_K    = 1'b0;

endpackage

// File: rtl/usbdev_fs_tx_if.sv
// Packet-engine handshake plus IO-mux pin bundle of the full-speed transmitter.
interface usbdev_fs_tx_if;

    logic       start_i;
    logic [7:0] data_i;
    logic       data_last_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       busy_o;
    logic       err_underrun_o;
    logic       usb_tx_d_o;
    logic       usb_tx_se0_o;
    logic       usb_tx_dp_o;
    logic       usb_tx_dn_o;
    logic       usb_tx_oe_o;

    modport master (
        output start_i, data_i, data_last_i, data_valid_i,
        input  data_ready_o, busy_o, err_underrun_o,
        input  usb_tx_d_o, usb_tx_se0_o, usb_tx_dp_o, usb_tx_dn_o, usb_tx_oe_o
    );

    modport slave (
        input  start_i, data_i, data_last_i, data_valid_i,
        output data_ready_o, busy_o, err_underrun_o,
        output usb_tx_d_o, usb_tx_se0_o, usb_tx_dp_o, usb_tx_dn_o, usb_tx_oe_o
    );

endinterface

// File: rtl/usbdev_nrzi_stuff.sv
// NRZI encoder and ones counter: on each bit strobe the raw bit updates the line level,
// and stuff_req flags that the next bit time must carry a stuffed zero.
module usbdev_nrzi_stuff
    import usbdev_pkg::*;
#(
    parameter int StuffLimit = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic bit_stb,
    input  logic bit_val,
    output logic stuff_req,
    output logic d_nxt
);

    localparam int OW = $clog2(StuffLimit + 1);

    logic          level;
    logic [OW-1:0] ones;
    logic          base_level;
    logic [OW-1:0] base_ones;

    // init lets the first SYNC bit be encoded from a fresh J / zero-count state
    always_comb begin
        base_level = init ? USB_LINE_J : level;
        base_ones  = init ? '0 : ones;
        d_nxt      = bit_val ? base_level
                             : ((base_level == USB_LINE_J) ? USB_LINE_K : USB_LINE_J);
    end

    assign stuff_req = (ones == OW'(StuffLimit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= USB_LINE_J;
            ones  <= '0;
        end else if (bit_stb) begin
            level <= d_nxt;
            ones  <= bit_val ? base_ones + OW'(1) : '0;
        end
    end

endmodule

// File: rtl/usbdev_fs_tx.sv
// Full-speed USB line transmitter: SYNC, NRZI + bit stuffing, EOP, with a one-entry byte buffer.
// Define USBDEV_FS_TX_IDLE_LEAD_EN to drive one J bit time (PRE state) before SYNC.
module usbdev_fs_tx
    import usbdev_pkg::*;
#(
    parameter int ClkPerBit  = 4,
    parameter int StuffLimit = 6,
    parameter int EopSe0Bits = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    usbdev_fs_tx_if.slave  bus
);

    localparam int PW = $clog2(ClkPerBit);
    localparam int EW = (EopSe0Bits > 1) ? $clog2(EopSe0Bits) : 1;

    usb_tx_state_e state, state_nxt;
    logic [PW-1:0] phase;
    logic [6:0]    sh;
    logic [2:0]    bits_left;
    logic          cur_last;
    logic [7:0]    buf_data;
    logic          buf_last;
    logic          buf_full;
    logic          no_more;
    logic [EW-1:0] eop_cnt;
    logic          d_r, se0_r, dp_r, dn_r, oe_r, err_r;

    logic busy, bit_end, ready, take;
    logic emit, emit_val, load_sync, load_buf, shift, underrun, eop_clr, eop_inc;
    logic pin_upd, pin_d, pin_se0, pin_oe, d_sel;
    logic nrzi_init, stuff_req, nrzi_d;

    assign busy    = (state != ST_IDLE);
    assign bit_end = busy && (phase == PW'(ClkPerBit - 1));
    assign ready   = busy && !buf_full && !no_more;
    assign take    = bus.data_valid_i && ready;

    assign nrzi_init = (state == ST_IDLE) || (state == ST_PRE);
    assign d_sel     = emit ? nrzi_d : pin_d;

    usbdev_nrzi_stuff #(
        .StuffLimit (StuffLimit)
    ) u_nrzi (
        .clk       (clk_i),
        .rst       (rst_i),
        .init      (nrzi_init),
        .bit_stb   (emit),
        .bit_val   (emit_val),
        .stuff_req (stuff_req),
        .d_nxt     (nrzi_d)
    );

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_val  = 1'b0;
        load_sync = 1'b0;
        load_buf  = 1'b0;
        shift     = 1'b0;
        underrun  = 1'b0;
        eop_clr   = 1'b0;
        eop_inc   = 1'b0;
        pin_upd   = 1'b0;
        pin_d     = USB_LINE_J;
        pin_se0   = 1'b0;
        pin_oe    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    pin_upd = 1'b1;
                    pin_oe  = 1'b1;
`ifdef USBDEV_FS_TX_IDLE_LEAD_EN
                    state_nxt = ST_PRE;
`else
                    state_nxt = ST_SYNC;
                    load_sync = 1'b1;
                    emit      = 1'b1;
                    emit_val  = USB_SYNC_BYTE[0];
`endif
                end
            end
`ifdef USBDEV_FS_TX_IDLE_LEAD_EN
            ST_PRE: begin
                if (bit_end) begin
                    state_nxt = ST_SYNC;
                    load_sync = 1'b1;
                    emit      = 1'b1;
                    emit_val  = USB_SYNC_BYTE[0];
                    pin_upd   = 1'b1;
                    pin_oe    = 1'b1;
                end
            end
`endif
            ST_SYNC, ST_DATA: begin
                // a pending stuff bit always goes out before the byte boundary is evaluated
                if (bit_end) begin
                    pin_upd = 1'b1;
                    pin_oe  = 1'b1;
                    if (stuff_req) begin
                        emit = 1'b1;
                    end else if (bits_left != 3'd0) begin
                        shift    = 1'b1;
                        emit     = 1'b1;
                        emit_val = sh[0];
                    end else if (cur_last) begin
                        state_nxt = ST_EOP_SE0;
                        eop_clr   = 1'b1;
                        pin_se0   = 1'b1;
                    end else if (buf_full) begin
                        state_nxt = ST_DATA;
                        load_buf  = 1'b1;
                        emit      = 1'b1;
                        emit_val  = buf_data[0];
                    end else begin
                        state_nxt = ST_EOP_SE0;
                        underrun  = 1'b1;
                        eop_clr   = 1'b1;
                        pin_se0   = 1'b1;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    pin_upd = 1'b1;
                    pin_oe  = 1'b1;
                    if (eop_cnt == EW'(EopSe0Bits - 1)) begin
                        state_nxt = ST_EOP_J;
                    end else begin
                        eop_inc = 1'b1;
                        pin_se0 = 1'b1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                    pin_upd   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            phase     <= '0;
            bits_left <= 3'd0;
            cur_last  <= 1'b0;
            buf_last  <= 1'b0;
            buf_full  <= 1'b0;
            no_more   <= 1'b0;
            eop_cnt   <= '0;
            d_r       <= USB_LINE_J;
            se0_r     <= 1'b0;
            dp_r      <= 1'b1;
            dn_r      <= 1'b0;
            oe_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_r <= underrun;

            if (busy) begin
                phase <= bit_end ? '0 : phase + PW'(1);
            end else begin
                phase <= '0;
            end

            if (!busy && bus.start_i) begin
                no_more <= 1'b0;
            end else if (underrun || (take && bus.data_last_i)) begin
                no_more <= 1'b1;
            end

            if (take) begin
                buf_full <= 1'b1;
                buf_last <= bus.data_last_i;
            end else if (load_buf) begin
                buf_full <= 1'b0;
            end

            if (load_sync) begin
                bits_left <= 3'd7;
                cur_last  <= 1'b0;
            end else if (load_buf) begin
                bits_left <= 3'd7;
                cur_last  <= buf_last;
            end else if (shift) begin
                bits_left <= bits_left - 3'd1;
            end

            if (eop_clr) begin
                eop_cnt <= '0;
            end else if (eop_inc) begin
                eop_cnt <= eop_cnt + EW'(1);
            end

            if (pin_upd) begin
                d_r   <= d_sel;
                se0_r <= pin_se0;
                dp_r  <= d_sel & ~pin_se0;
                dn_r  <= ~d_sel & ~pin_se0;
                oe_r  <= pin_oe;
            end
        end
    end

    // payload registers carry no reset; buf_full and bits_left qualify them
    always_ff @(posedge clk_i) begin
        if (take) begin
            buf_data <= bus.data_i;
        end
        if (load_sync) begin
            sh <= USB_SYNC_BYTE[7:1];
        end else if (load_buf) begin
            sh <= buf_data[7:1];
        end else if (shift) begin
            sh <= {1'b0, sh[6:1]};
        end
    end

    assign bus.data_ready_o   = ready;
    assign bus.busy_o         = busy;
    assign bus.err_underrun_o = err_r;
    assign bus.usb_tx_d_o     = d_r;
    assign bus.usb_tx_se0_o   = se0_r;
    assign bus.usb_tx_dp_o    = dp_r;
    assign bus.usb_tx_dn_o    = dn_r;
    assign bus.usb_tx_oe_o    = oe_r;

endmodule

// File: tb/tb_usbdev_fs_tx.sv
// Bench for usbdev_fs_tx: directed steps plus random packets against a bit-level line model.
module tb_usbdev_fs_tx;

    localparam int CPB   = 4;
    localparam int STUFF = 6;
    localparam int SE0B  = 2;
`ifdef USBDEV_FS_TX_IDLE_LEAD_EN
    localparam int LEAD = 1;
`else
    localparam int LEAD = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usbdev_fs_tx_if bus();

    usbdev_fs_tx dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pkt[$];
    int         exp_sym[$];     // 0 = K, 1 = J, 2 = SE0, one entry per bit time
    logic [3:0] cap[$];         // {d, se0, dp, dn} per clock while oe is high
    int         err_at[$];
    int         oe_len;

    int t2d[16] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0};
    int t3d[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line model: SYNC then payload bits LSB first, stuff after STUFF ones, NRZI from J, EOP.
    function automatic void build_model();
        bit         bits[$];
        bit         lvl;
        int         ones;
        logic [7:0] sync_b;
        sync_b = 8'h80;
        exp_sym.delete();
        for (int i = 0; i < LEAD; i++) exp_sym.push_back(1);
        for (int i = 0; i < 8; i++) bits.push_back(sync_b[i]);
        foreach (pkt[k]) begin
            for (int i = 0; i < 8; i++) bits.push_back(pkt[k][i]);
        end
        lvl  = 1'b1;
        ones = 0;
        foreach (bits[i]) begin
            if (bits[i]) ones++;
            else begin
                lvl  = !lvl;
                ones = 0;
            end
            exp_sym.push_back(int'(lvl));
            if (ones == STUFF) begin
                lvl  = !lvl;
                ones = 0;
                exp_sym.push_back(int'(lvl));
            end
        end
        for (int i = 0; i < SE0B; i++) exp_sym.push_back(2);
        exp_sym.push_back(1);
    endfunction

    function automatic logic [3:0] symvec(input int s);
        case (s)
            0:       return 4'b0001;
            1:       return 4'b1010;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [7:0] idle_vec();
        return {bus.usb_tx_oe_o, bus.usb_tx_d_o, bus.usb_tx_se0_o, bus.usb_tx_dp_o,
                bus.usb_tx_dn_o, bus.busy_o, bus.data_ready_o, bus.err_underrun_o};
    endfunction

    task automatic wait_ready(output bit ok);
        int w;
        w  = 0;
        ok = 1'b0;
        while (w < 200) begin
            @(negedge clk);
            if (bus.data_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            w++;
        end
    endtask

    task automatic send_packet(input bit under, input bit b2b, input bit extra_start);
        bit drv_ok;
        int se0_start;
        int n;
        build_model();
        cap.delete();
        err_at.delete();
        drv_ok = 1'b1;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        fork
            begin
                foreach (pkt[k]) begin
                    bit ok;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    bus.data_i       = pkt[k];
                    bus.data_last_i  = !under && (k == pkt.size() - 1);
                    bus.data_valid_i = 1'b1;
                    wait_ready(ok);
                    if (!ok) drv_ok = 1'b0;
                    @(posedge clk);
                    #1;
                    bus.data_valid_i = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (cyc < 1000) begin
                    @(negedge clk);
                    if (bus.usb_tx_oe_o !== 1'b1) break;
                    cap.push_back({bus.usb_tx_d_o, bus.usb_tx_se0_o, bus.usb_tx_dp_o, bus.usb_tx_dn_o});
                    chk("busy_while_oe", bus.busy_o, 1);
                    if (under && err_at.size() > 0) chk("late_byte_ready", bus.data_ready_o, 0);
                    if (bus.err_underrun_o === 1'b1) begin
                        err_at.push_back(cyc);
                        if (under) begin
                            bus.data_i       = 8'h5A;
                            bus.data_last_i  = 1'b1;
                            bus.data_valid_i = 1'b1;
                        end
                    end
                    cyc++;
                end
                oe_len = cyc;
                bus.data_valid_i = 1'b0;
                chk("oe_fall_seen", 32'(cyc < 1000), 1);
                chk("busy_fall", bus.busy_o, 0);
            end
            begin
                if (extra_start) begin
                    repeat ($urandom_range(5, 60)) @(posedge clk);
                    #1;
                    bus.start_i = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.start_i = 1'b0;
                end
            end
        join
        chk("driver_done", 32'(drv_ok), 1);
        chk("oe_len", oe_len, 32'(CPB * exp_sym.size()));
        n = (cap.size() < CPB * exp_sym.size()) ? cap.size() : CPB * exp_sym.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("pins@%0d", i), 32'(cap[i]), 32'(symvec(exp_sym[i / CPB])));
        end
        chk("err_count", err_at.size(), 32'(under));
        if (under && err_at.size() > 0) begin
            se0_start = CPB * (exp_sym.size() - SE0B - 1);
            chk("err_pos", 32'(err_at[0] >= se0_start - 1 && err_at[0] <= se0_start), 1);
        end
    endtask

    task automatic check_d_bits(input string tag, input int first_bit, input int nb, input int ref_bits[]);
        logic v;
        int   idx;
        for (int i = 0; i < nb; i++) begin
            idx = CPB * (LEAD + first_bit + i) + CPB / 2;
            v   = (idx < cap.size()) ? cap[idx][3] : 1'bz;
            chk($sformatf("%s_bit%0d", tag, i), 32'(v), 32'(ref_bits[i]));
        end
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.data_i       = 8'h00;
        bus.data_last_i  = 1'b0;
        bus.data_valid_i = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_state", idle_vec(), 8'b0101_0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_state", idle_vec(), 8'b0101_0000);

        // single last byte 0x2D
        pkt = '{8'h2D};
        send_packet(1'b0, 1'b0, 1'b0);
        check_d_bits("t2", 0, 16, t2d);
        chk("t2_oe_clk", oe_len, 32'(76 + 4 * LEAD));

        // 0xFF forces a stuff bit after the fifth data one
        pkt = '{8'hFF};
        send_packet(1'b0, 1'b0, 1'b0);
        check_d_bits("t3", 8, 9, t3d);
        chk("t3_oe_clk", oe_len, 32'(80 + 4 * LEAD));

        // non-last byte with nothing following: underrun at the second byte boundary
        pkt = '{8'h00};
        send_packet(1'b1, 1'b0, 1'b0);
        chk("t4_oe_clk", oe_len, 32'(76 + 4 * LEAD));

        // start pulses while busy are ignored; start on the busy-fall cycle is accepted
        pkt = '{8'($urandom), 8'($urandom)};
        send_packet(1'b0, 1'b0, 1'b1);
        pkt = '{8'($urandom)};
        send_packet(1'b0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a data byte
        begin
            bit ok;
            @(posedge clk);
            #1;
            bus.start_i = 1'b1;
            @(posedge clk);
            #1;
            bus.start_i      = 1'b0;
            bus.data_i       = 8'hA5;
            bus.data_last_i  = 1'b1;
            bus.data_valid_i = 1'b1;
            wait_ready(ok);
            chk("t1_byte_taken", 32'(ok), 1);
            @(posedge clk);
            #1;
            bus.data_valid_i = 1'b0;
            repeat (40) @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("t1_midpkt_reset", idle_vec(), 8'b0101_0000);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("t1_after_reset", idle_vec(), 8'b0101_0000);
        end
        pkt = '{8'($urandom), 8'hFF};
        send_packet(1'b0, 1'b0, 1'b0);

        // random packets, biased toward 0xFF to exercise stuffing
        for (int r = 0; r < 12; r++) begin
            int nb;
            bit under;
            bit b2b;
            bit xs;
            nb    = $urandom_range(1, 4);
            under = ($urandom_range(0, 3) == 0);
            b2b   = ($urandom_range(0, 2) == 0);
            xs    = ($urandom_range(0, 2) == 0);
            pkt.delete();
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 2) == 0) pkt.push_back(8'hFF);
                else pkt.push_back(8'($urandom));
            end
            send_packet(under, b2b, xs);
        end

        repeat (4) @(negedge clk);
        chk("final_idle", idle_vec(), 8'b0101_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
